// File: rtl/dram_port_arbiter.sv
// dram_port_arbiter: two-requester round-robin arbiter in front of a single-port
// synchronous-read RAM. Read data returns one cycle after the read grant.
// Optional power-up clear of the whole RAM is compiled in with CLEAR_ON_RESET_EN.
module dram_port_arbiter #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              busy
);

    logic              last_q;    // 1 = m1 was granted last, so m0 wins the next contention
    logic              pend0_q;
    logic              pend1_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] din_q;
    logic              clearing;
    logic [ADDR_W-1:0] clr_addr;
    logic              g0;
    logic              g1;

`ifdef CLEAR_ON_RESET_EN
    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    logic [0:0]        state_q;
    logic [0:0]        state_d;
    logic [ADDR_W-1:0] clr_q;

    // Leave CLEAR once the top address has been written.
    always_comb begin
        state_d = state_q;
        if (state_q == ST_CLEAR && clr_q == {ADDR_W{1'b1}}) begin
            state_d = ST_RUN;
        end
    end

    // Clear FSM and address sweep; reset restarts the sweep from address 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            clr_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_CLEAR) begin
                clr_q <= clr_q + 1'b1;
            end
        end
    end

    assign clearing = (state_q == ST_CLEAR);
    assign clr_addr = clr_q;
`else
    assign clearing = 1'b0;
    assign clr_addr = '0;
`endif

    // Grant: the lone requester wins; on contention the one not granted last wins.
    always_comb begin
        g0 = 1'b0;
        g1 = 1'b0;
        if (!rst && !clearing) begin
            if (m0_req && m1_req) begin
                g0 = last_q;
                g1 = !last_q;
            end else begin
                g0 = m0_req;
                g1 = m1_req;
            end
        end
    end

    assign m0_gnt = g0;
    assign m1_gnt = g1;

    // RAM port mux; without a grant the address and data hold their last values.
    always_comb begin
        mem_we   = 1'b0;
        mem_addr = addr_q;
        mem_din  = din_q;
        if (!rst && clearing) begin
            mem_we   = 1'b1;
            mem_addr = clr_addr;
            mem_din  = '0;
        end else if (g0) begin
            mem_we   = m0_we;
            mem_addr = m0_addr;
            mem_din  = m0_wdata;
        end else if (g1) begin
            mem_we   = m1_we;
            mem_addr = m1_addr;
            mem_din  = m1_wdata;
        end
    end

    // Pointer, read-pending flags, held read data and held RAM port values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q   <= 1'b1;
            pend0_q  <= 1'b0;
            pend1_q  <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            addr_q   <= '0;
            din_q    <= '0;
        end else begin
            if (g0) begin
                last_q <= 1'b0;
            end else if (g1) begin
                last_q <= 1'b1;
            end
            pend0_q <= g0 && !m0_we;
            pend1_q <= g1 && !m1_we;
            if (pend0_q) begin
                rdata0_q <= mem_dout;
            end
            if (pend1_q) begin
                rdata1_q <= mem_dout;
            end
            addr_q <= mem_addr;
            din_q  <= mem_din;
        end
    end

    assign m0_rvalid = pend0_q;
    assign m1_rvalid = pend1_q;
    // Pass RAM data straight through on the response cycle, otherwise hold.
    assign m0_rdata  = pend0_q ? mem_dout : rdata0_q;
    assign m1_rdata  = pend1_q ? mem_dout : rdata1_q;
    assign busy      = !rst && (clearing || pend0_q || pend1_q);

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Directed bench for dram_port_arbiter with a behavioural synchronous-read RAM,
// a shadow memory model and per-requester queues of expected read data.
// Build with CLEAR_ON_RESET_EN defined to exercise the power-up clear.
module tb_dram_port_arbiter;
    localparam int AW = 8;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
    logic [AW-1:0] m0_addr = '0, m1_addr = '0;
    logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
    logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_we, busy;
    logic [DW-1:0] m0_rdata, m1_rdata, mem_din;
    logic [DW-1:0] mem_dout = '0;
    logic [AW-1:0] mem_addr;

    dram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Single-port RAM, read-before-write, one-cycle read latency.
    logic [DW-1:0] ram [0:255];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_din;
        mem_dout <= ram[mem_addr];
    end

    int            total = 0;
    int            bad = 0;
    logic [DW-1:0] shadow [0:255];
    logic [DW-1:0] q0 [$];
    logic [DW-1:0] q1 [$];
    logic          pend0 = 1'b0, pend1 = 1'b0;
    logic [DW-1:0] last0 = '0, last1 = '0;
    logic [AW-1:0] exp_addr = '0;
    logic [DW-1:0] exp_din = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks responses launched by the previous clock edge.
    task automatic chk_resp(input string tag);
        logic [DW-1:0] e;
        chk({tag, ".rv0"}, m0_rvalid, pend0);
        chk({tag, ".rv1"}, m1_rvalid, pend1);
        chk({tag, ".busy"}, busy, pend0 | pend1);
        if (pend0 && q0.size() > 0) begin
            e = q0.pop_front();
            last0 = e;
        end
        if (pend1 && q1.size() > 0) begin
            e = q1.pop_front();
            last1 = e;
        end
        chk({tag, ".rd0"}, m0_rdata, last0);
        chk({tag, ".rd1"}, m1_rdata, last1);
    endtask

    task automatic step(input logic r0, input logic w0, input logic [AW-1:0] a0,
                        input logic [DW-1:0] d0, input logic r1, input logic w1,
                        input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                        input logic eg0, input logic eg1, input string tag);
        @(negedge clk);
        chk_resp(tag);
        m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
        m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
        #1;
        chk({tag, ".g0"}, m0_gnt, eg0);
        chk({tag, ".g1"}, m1_gnt, eg1);
        chk({tag, ".mwe"}, mem_we, (eg0 & w0) | (eg1 & w1));
        pend0 = 1'b0;
        pend1 = 1'b0;
        if (eg0) begin
            exp_addr = a0; exp_din = d0;
            if (w0) shadow[a0] = d0;
            else begin q0.push_back(shadow[a0]); pend0 = 1'b1; end
        end else if (eg1) begin
            exp_addr = a1; exp_din = d1;
            if (w1) shadow[a1] = d1;
            else begin q1.push_back(shadow[a1]); pend1 = 1'b1; end
        end
        chk({tag, ".maddr"}, mem_addr, exp_addr);
        chk({tag, ".mdin"}, mem_din, exp_din);
    endtask

    task automatic model_reset();
        pend0 = 1'b0; pend1 = 1'b0;
        q0.delete(); q1.delete();
        last0 = '0; last1 = '0;
        exp_addr = '0; exp_din = '0;
    endtask

    task automatic release_rst();
        m0_req = 1'b0; m1_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
`ifdef CLEAR_ON_RESET_EN
        m0_req = 1'b1; m0_we = 1'b0;
        for (int i = 0; i < 256; i++) begin
            #1;
            chk("clr.busy", busy, 1'b1);
            chk("clr.gnt", m0_gnt, 1'b0);
            chk("clr.addr", mem_addr, i[AW-1:0]);
            @(negedge clk);
        end
        chk("clr.done", busy, 1'b0);
        m0_req = 1'b0;
        for (int i = 0; i < 256; i++) shadow[i] = '0;
        exp_addr = 8'hFF; exp_din = '0;
`endif
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin ram[i] = '0; shadow[i] = '0; end
        m0_req = 1'b1; m1_req = 1'b1; m0_addr = 8'h33; m0_wdata = 32'h1234;
        @(posedge clk); @(posedge clk); #1;
        chk("rst.g0", m0_gnt, 1'b0);
        chk("rst.g1", m1_gnt, 1'b0);
        chk("rst.rv0", m0_rvalid, 1'b0);
        chk("rst.rd0", m0_rdata, '0);
        chk("rst.mwe", mem_we, 1'b0);
        chk("rst.maddr", mem_addr, '0);
        chk("rst.mdin", mem_din, '0);
        chk("rst.busy", busy, 1'b0);
        release_rst();

        // First contention after reset goes to m0, then strict alternation.
        step(1, 1, 8'h20, 32'hAAAA0001, 1, 1, 8'h21, 32'hBBBB0002, 1, 0, "c_first");
        step(1, 0, 8'h20, 0, 1, 1, 8'h21, 32'hBBBB0002, 0, 1, "c_wr1");
        step(1, 0, 8'h20, 0, 1, 0, 8'h21, 0, 1, 0, "c_rd_a");
        step(1, 0, 8'h20, 0, 1, 0, 8'h21, 0, 0, 1, "c_rd_b");
        step(1, 0, 8'h20, 0, 1, 0, 8'h21, 0, 1, 0, "c_rd_c");
        step(1, 0, 8'h20, 0, 1, 0, 8'h21, 0, 0, 1, "c_rd_d");
        // Single requester write then read.
        step(1, 1, 8'h10, 32'hDEADBEEF, 0, 0, 0, 0, 1, 0, "s_wr");
        step(1, 0, 8'h10, 0, 0, 0, 0, 0, 1, 0, "s_rd");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "s_idle");
        // Read-during-write: m1 reads in N, m0 overwrites in N+1.
        step(0, 0, 0, 0, 1, 1, 8'h05, 32'h1, 0, 1, "rw_init");
        step(0, 0, 0, 0, 1, 0, 8'h05, 0, 0, 1, "rw_rd");
        step(1, 1, 8'h05, 32'h2, 0, 0, 0, 0, 1, 0, "rw_wr");
        step(1, 0, 8'h05, 0, 0, 0, 0, 0, 1, 0, "rw_rd2");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "rw_idle");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "hold");
        // Reset during a pending read.
        step(1, 1, 8'hFF, 32'hFFFFFFFF, 0, 0, 0, 0, 1, 0, "ff_wr");
        step(1, 0, 8'h10, 0, 0, 0, 0, 0, 1, 0, "mr_rd");
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("mr.rv0", m0_rvalid, 1'b0);
        chk("mr.rd0", m0_rdata, '0);
        chk("mr.g0", m0_gnt, 1'b0);
        chk("mr.busy", busy, 1'b0);
        chk("mr.maddr", mem_addr, '0);
        model_reset();
        release_rst();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "mr_post1");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "mr_post2");
        // Pointer reset again; 0xFF reads back cleared or written data.
        step(1, 0, 8'hFF, 0, 1, 0, 8'h10, 0, 1, 0, "p_c0");
        step(0, 0, 0, 0, 1, 0, 8'h10, 0, 0, 1, "p_c1");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "end1");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "end2");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dram_port_arbiter.md
DRAM_PORT_ARBITER -- requirements
Module: dram_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, memory address width (256 words).
REQ-002 SHALL have parameter DATA_W, default 32, memory data width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports m0_req / m1_req  input  1  requester access request; held with its fields until granted.
REQ-006 SHALL have ports m0_we / m1_we  input  1  1 = write, 0 = read.
REQ-007 SHALL have ports m0_addr / m1_addr  input  ADDR_W  access address.
REQ-008 SHALL have ports m0_wdata / m1_wdata  input  DATA_W  write data.
REQ-009 SHALL have ports m0_gnt / m1_gnt  output  1  combinational grant; the access transfers in the cycle where req and gnt are both 1.
REQ-010 SHALL have ports m0_rvalid / m1_rvalid  output  1  read data valid, one-cycle pulse.
REQ-011 SHALL have ports m0_rdata / m1_rdata  output  DATA_W  read data, meaningful only while rvalid = 1.
REQ-012 SHALL have ports mem_we  output  1, mem_addr  output  ADDR_W, mem_din  output  DATA_W; these drive the single-port synchronous-read RAM.
REQ-013 SHALL have port mem_dout  input  DATA_W  RAM read data, valid one cycle after the address is presented.
REQ-014 SHALL have port busy  output  1  high while clearing or while a read response is outstanding.

Function
REQ-015 SHALL grant at most one requester per cycle; m0_gnt and m1_gnt are never 1 together.
REQ-016 SHALL grant the only requester when exactly one requester has req = 1, with no idle cycle.
REQ-017 SHALL arbitrate round-robin when both requesters have req = 1: grant the requester not granted last; the last-grant pointer updates only on a grant.
REQ-018 SHALL drive mem_we, mem_addr and mem_din combinationally from the granted requester; with no grant, mem_we = 0 and mem_addr/mem_din hold their last values.
REQ-019 SHALL pulse the granted requester's rvalid exactly one cycle after a granted read (latency 1); rdata = mem_dout in that cycle.
REQ-020 SHALL generate no rvalid for a granted write.
REQ-021 SHALL allow back-to-back grants every cycle, including a read followed by a write to the same address; the read returns the old data.
REQ-022 SHALL hold rdata at its last value while rvalid = 0.
REQ-023 SHALL run a state machine with states CLEAR and RUN; CLEAR exists only under REQ-030.

Reset
REQ-024 SHALL force gnt = 0, rvalid = 0, rdata = 0, mem_we = 0, mem_addr = 0, mem_din = 0 and busy = 0 immediately while rst = 1, independent of clk.
REQ-025 SHALL reset the last-grant pointer so that m0 wins the first contention.
REQ-026 SHALL discard a read in flight when rst asserts mid-operation; no rvalid follows reset release.
REQ-027 SHALL enter CLEAR after reset release when REQ-030 is compiled in; otherwise it SHALL enter RUN.

Configuration
REQ-028 SHALL use macro CLEAR_ON_RESET_EN to select the power-up clear feature.
REQ-029 SHALL, without CLEAR_ON_RESET_EN, omit the CLEAR state; requests are granted in the first cycle after reset release.
REQ-030 SHALL, with CLEAR_ON_RESET_EN, write 0 to addresses 0 through 2^ADDR_W-1 in ascending order, one per cycle (256 cycles), with busy = 1 and both gnt = 0; the block SHALL enter RUN in the cycle after address 255 is written.
REQ-031 SHALL restart the clear from address 0 when rst asserts during CLEAR.

Verification
REQ-032 SHALL cover a single-requester write then read: m0 writes 0xDEADBEEF to address 0x10, then reads 0x10 -> m0_gnt = 1 in each request cycle; m0_rvalid = 1 one cycle after the read grant with m0_rdata = 0xDEADBEEF; m1_rvalid stays 0.
REQ-033 SHALL cover contention: both requesters hold read requests for 4 cycles -> grants alternate m0, m1, m0, m1; each rvalid appears one cycle after its own grant.
REQ-034 SHALL cover read-during-write: address 0x05 holds 0x1; m1 reads 0x05 in cycle N and m0 writes 0x2 to 0x05 in cycle N+1 -> m1_rdata = 0x1; a later read returns 0x2.
REQ-035 SHALL cover reset mid-read: rst asserts in the cycle after an m0 read grant -> m0_rvalid = 0 immediately and no rvalid follows reset release.
REQ-036 SHALL cover clear (with CLEAR_ON_RESET_EN): first write 0xFFFFFFFF to address 0xFF, then reset -> busy = 1 and gnt = 0 for 256 cycles; a subsequent read of 0xFF returns 0x00000000.
